// File: rtl/adder_pipelined_wrapper.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into STAGES registered
// segments behind an input register, with a global-stall valid/ready handshake.
module adder_pipelined_wrapper #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG = (STAGES > 0) ? WIDTH / STAGES : 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("adder_pipelined_wrapper: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Index 0 is the input register; index k+1 holds the result of segment k.
    logic [WIDTH-1:0] r_a [0:STAGES-1];
    logic [WIDTH-1:0] r_b [0:STAGES-1];
    logic [WIDTH-1:0] r_s [0:STAGES];
    logic             r_c [0:STAGES];
    logic             r_v [0:STAGES];
    logic             r_ovf;

    logic [SEG:0]     w_seg [0:STAGES-1];
    logic             w_ovf;
    logic             w_advance;

    assign w_advance = !r_v[STAGES] || out_ready;

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, r_a[k][k*SEG +: SEG]} + {1'b0, r_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, r_c[k]};
        end
    end

    // The MSB lives in the last segment, so overflow is known one step before output.
    assign w_ovf = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
                && (w_seg[STAGES-1][SEG-1] != r_a[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= STAGES; k++) begin
                r_v[k] <= 1'b0;
            end
            r_s[STAGES] <= '0;
            r_c[STAGES] <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_v[0] <= in_valid;
            r_a[0] <= a;
            r_b[0] <= sub ? ~b : b;
            r_c[0] <= sub ? 1'b1 : cin;
            r_s[0] <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k+1]                  <= r_v[k];
                r_c[k+1]                  <= w_seg[k][SEG];
                r_s[k+1]                  <= r_s[k];
                r_s[k+1][k*SEG +: SEG]    <= w_seg[k][SEG-1:0];
            end
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                r_a[k+1] <= r_a[k];
                r_b[k+1] <= r_b[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_v[STAGES];
    assign sum       = r_s[STAGES];
    assign cout      = r_c[STAGES];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_pipelined_wrapper.sv
// Scoreboard bench for adder_pipelined_wrapper over three width/depth configurations.
// One configuration is selected at a time; inputs are shared, in_valid is steered.
module tb_adder_pipelined_wrapper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin_d = 1'b0;
    logic        sub_d = 1'b0;
    logic [63:0] a_d = '0;
    logic [63:0] b_d = '0;
    int          sel = 0;
    int          cur_w = 32;
    int          cur_lat = 5;

    logic        iv32, ir32, ov32, co32, of32;
    logic [31:0] s32;
    logic        iv8, ir8, ov8, co8, of8;
    logic [7:0]  s8;
    logic        iv64, ir64, ov64, co64, of64;
    logic [63:0] s64;

    assign iv32 = iv && (sel == 0);
    assign iv8  = iv && (sel == 1);
    assign iv64 = iv && (sel == 2);

    adder_pipelined_wrapper #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a_d[31:0]), .b(b_d[31:0]),
        .cin(cin_d), .sub(sub_d), .out_valid(ov32), .out_ready(out_ready), .sum(s32),
        .cout(co32), .ovf(of32));

    adder_pipelined_wrapper #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a_d[7:0]), .b(b_d[7:0]),
        .cin(cin_d), .sub(sub_d), .out_valid(ov8), .out_ready(out_ready), .sum(s8),
        .cout(co8), .ovf(of8));

    adder_pipelined_wrapper #(.WIDTH(64), .STAGES(8)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a_d), .b(b_d),
        .cin(cin_d), .sub(sub_d), .out_valid(ov64), .out_ready(out_ready), .sum(s64),
        .cout(co64), .ovf(of64));

    logic        o_in_ready, o_valid, o_cout, o_ovf;
    logic [63:0] o_sum;

    always_comb begin
        o_in_ready = ir32; o_valid = ov32; o_sum = {32'd0, s32}; o_cout = co32; o_ovf = of32;
        case (sel)
            1: begin o_in_ready = ir8;  o_valid = ov8;  o_sum = {56'd0, s8}; o_cout = co8;  o_ovf = of8;  end
            2: begin o_in_ready = ir64; o_valid = ov64; o_sum = s64;         o_cout = co64; o_ovf = of64; end
            default: ;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    logic [65:0] sbq[$];
    logic [65:0] sb_exp;

    // Plain full-width behavioural reference: {ovf, cout, sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s);
        logic [63:0] mask, am, bm, sm;
        logic [64:0] full;
        logic        co, ov;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = (s ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bm} + {64'd0, (s ? 1'b1 : c)};
        sm   = full[63:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (o_valid && out_ready) begin
                pops++;
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_spurious: got sum=%h cout=%b ovf=%b, expected no result",
                             o_sum, o_cout, o_ovf);
                end else begin
                    sb_exp = sbq.pop_front();
                    if ({o_ovf, o_cout, o_sum} !== sb_exp) begin
                        miscompares++;
                        $display("FAIL sb_result w=%0d: got ovf/cout/sum=%b/%b/%h, expected %b/%b/%h",
                                 cur_w, o_ovf, o_cout, o_sum, sb_exp[65], sb_exp[64], sb_exp[63:0]);
                    end
                end
            end
            if (iv && o_in_ready)
                sbq.push_back(model(cur_w, a_d, b_d, cin_d, sub_d));
        end
    end

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        a_d = a; b_d = b; cin_d = c; sub_d = s; iv = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", o_valid); end
        if (o_sum !== 64'd0) begin miscompares++; $display("FAIL reset_sum: got %h, expected 0", o_sum); end
        if (o_cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b, expected 0", o_cout); end
        if (o_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, expected 0", o_ovf); end
        if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", o_in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s, input logic [63:0] es,
                                 input logic ec, input logic eo);
        int n;
        out_ready = 1'b1;
        drive(a, b, c, s);
        @(posedge clk); #1;
        iv = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors += 4;
        if (n != cur_lat) begin miscompares++; $display("FAIL %s_latency: got %0d, expected %0d", name, n, cur_lat); end
        if (o_sum !== es) begin miscompares++; $display("FAIL %s_sum: got %h, expected %h", name, o_sum, es); end
        if (o_cout !== ec) begin miscompares++; $display("FAIL %s_cout: got %b, expected %b", name, o_cout, ec); end
        if (o_ovf !== eo) begin miscompares++; $display("FAIL %s_ovf: got %b, expected %b", name, o_ovf, eo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int n);
        int vcount;
        out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < n + cur_lat; i++) begin
            if (i < n)
                drive({$urandom, $urandom}, {$urandom, $urandom},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                iv = 1'b0;
            @(posedge clk); #1;
            if (o_valid) vcount++;
        end
        vectors += 2;
        if (vcount != n) begin miscompares++; $display("FAIL b2b_throughput: got %0d valid cycles, expected %0d", vcount, n); end
        if (sbq.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d outstanding, expected 0", sbq.size()); end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        int p0;
        out_ready = 1'b1;
        for (int i = 0; i < cur_lat; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        drive(64'h1234, 64'h4321, 1'b0, 1'b0);
        held = o_sum;
        p0 = pops;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors += 3;
            if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, expected 0", o_in_ready); end
            if (o_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b, expected 1", o_valid); end
            if (o_sum !== held) begin miscompares++; $display("FAIL bp_hold: got %h, expected %h", o_sum, held); end
            @(posedge clk); #1;
        end
        iv = 1'b0;
        out_ready = 1'b1;
        repeat (cur_lat + 5) @(posedge clk);
        #1;
        vectors += 2;
        if (pops - p0 != cur_lat) begin miscompares++; $display("FAIL bp_count: got %0d results, expected %0d", pops - p0, cur_lat); end
        if (sbq.size() != 0) begin miscompares++; $display("FAIL bp_drain: got %0d outstanding, expected 0", sbq.size()); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(64'd99, 64'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        iv = 1'b0;
        vectors += 2;
        if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b, expected 0", o_valid); end
        if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b, expected 1", o_in_ready); end
        repeat (cur_lat + 6) @(posedge clk);
        #1;
        test_directed("post_reset", 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);
    endtask

    initial begin
        sel = 0; cur_w = 32; cur_lat = 5;
        test_reset();
        test_directed("w32_carry",   64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0);
        test_directed("w32_sub_neg", 64'h5,        64'h7, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0);
        test_directed("w32_sub_pos", 64'h7,        64'h5, 1'b1, 1'b1, 64'h2,        1'b1, 1'b0);
        test_directed("w32_ovf_add", 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1);
        test_directed("w32_ovf_sub", 64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1);
        test_directed("w32_cin",     64'h1,        64'h1, 1'b1, 1'b0, 64'h3,        1'b0, 1'b0);
        test_back_to_back(1000);
        test_backpressure();
        test_reset_midstream();

        sel = 1; cur_w = 8; cur_lat = 2;
        test_directed("w8_carry",   64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0);
        test_directed("w8_ovf_add", 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
        test_back_to_back(200);

        sel = 2; cur_w = 64; cur_lat = 9;
        test_directed("w64_carry",  64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        test_directed("w64_borrow", 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        test_back_to_back(200);
        test_backpressure();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
